// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED count sequencer.
package led_seq_pkg;

    localparam int LED_W     = 4;
    localparam int RATE_W    = 2;
    localparam int NUM_RATES = 4;

    localparam logic [LED_W-1:0] LED_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HOLD
    } seq_state_t;

    // Rate index advances 0..NUM_RATES-1 and wraps back to 0.
    function automatic logic [RATE_W-1:0] next_rate(input logic [RATE_W-1:0] rate);
        return (int'(rate) == NUM_RATES - 1) ? '0 : rate + RATE_W'(1);
    endfunction

endpackage

// File: rtl/led_count_sequencer_tick_gen.sv
// Rate-selectable prescaler: counts 0..P-1 while enabled, P = BASE_TICKS >> rate_sel.
// step is the combinational terminal-count strobe; tick is its registered copy.
module tick_gen
    import led_seq_pkg::*;
#(
    parameter int BASE_TICKS = 12_000_000,
    parameter int PRESC_W    = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              clear,
    input  logic [RATE_W-1:0] rate_sel,
    output logic              step,
    output logic              tick
);

    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] period_m1;

    assign period_m1 = PRESC_W'(BASE_TICKS >> rate_sel) - PRESC_W'(1);
    // A clear in the same cycle as terminal count swallows the step.
    assign step      = enable & ~clear & (presc_q == period_m1);

    // NOTE: sequential state is updated only with non-blocking assignments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            tick    <= 1'b0;
        end else begin
            tick <= step;
            if (clear || step) begin
                presc_q <= '0;
            end else if (enable) begin
                presc_q <= presc_q + PRESC_W'(1);
            end
        end
    end

endmodule

// File: rtl/led_count_sequencer.sv
// Button-driven sequencer for the 4-bit LED counter: go/pause, clear, rate cycling.
// Build option: define AUTO_REVERSE_EN for up/down bounce counting instead of wrap.
module led_count_sequencer
    import led_seq_pkg::*;
#(
    parameter int CLK_HZ     = 12_000_000,
    parameter int BASE_TICKS = 12_000_000,
    parameter int PRESC_W    = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_go,
    input  logic              btn_clr,
    input  logic              btn_rate,
    output logic [LED_W-1:0]  led,
    output logic              running,
    output logic [RATE_W-1:0] rate_sel,
    output logic              tick,
    output logic              wrap
);

    if (CLK_HZ < 1 || (BASE_TICKS >> 3) < 1 || (BASE_TICKS >> PRESC_W) != 0) begin : g_bad_params
        $error("led_count_sequencer: invalid CLK_HZ/BASE_TICKS/PRESC_W");
    end

    seq_state_t state_q, state_d;
    logic       go_q, clr_q, rate_q;
    logic       go_press, clr_press, rate_press;
    logic       step;
    logic [LED_W-1:0] led_d;
    logic       wrap_d;

    assign go_press   = btn_go   & ~go_q;
    assign clr_press  = btn_clr  & ~clr_q;
    assign rate_press = btn_rate & ~rate_q;
    assign running    = (state_q == ST_RUN);

    tick_gen #(
        .BASE_TICKS (BASE_TICKS),
        .PRESC_W    (PRESC_W)
    ) u_tick_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (state_q == ST_RUN),
        .clear    (clr_press | rate_press | (state_q == ST_IDLE)),
        .rate_sel (rate_sel),
        .step     (step),
        .tick     (tick)
    );

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (clr_press) begin
            state_d = ST_IDLE;
        end else if (go_press) begin
            case (state_q)
                ST_IDLE: state_d = ST_RUN;
                ST_RUN:  state_d = ST_HOLD;
                ST_HOLD: state_d = ST_RUN;
                default: state_d = ST_IDLE;
            endcase
        end
    end

`ifdef AUTO_REVERSE_EN
    logic dir_down_q, dir_down_d;

    always_comb begin
        led_d      = led;
        wrap_d     = 1'b0;
        dir_down_d = dir_down_q;
        if (clr_press) begin
            led_d      = '0;
            dir_down_d = 1'b0;
        end else if (step) begin
            if (!dir_down_q && led == LED_MAX) begin
                led_d      = LED_MAX - LED_W'(1);
                dir_down_d = 1'b1;
                wrap_d     = 1'b1;
            end else if (dir_down_q && led == '0) begin
                led_d      = LED_W'(1);
                dir_down_d = 1'b0;
                wrap_d     = 1'b1;
            end else begin
                led_d = dir_down_q ? led - LED_W'(1) : led + LED_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dir_down_q <= 1'b0;
        else        dir_down_q <= dir_down_d;
    end
`else
    always_comb begin
        led_d  = led;
        wrap_d = 1'b0;
        if (clr_press) begin
            led_d = '0;
        end else if (step) begin
            led_d  = led + LED_W'(1);
            wrap_d = (led == LED_MAX);
        end
    end
`endif

    // History resets high so a button held through reset is not taken as a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            go_q     <= 1'b1;
            clr_q    <= 1'b1;
            rate_q   <= 1'b1;
            led      <= '0;
            wrap     <= 1'b0;
            rate_sel <= '0;
        end else begin
            state_q <= state_d;
            go_q    <= btn_go;
            clr_q   <= btn_clr;
            rate_q  <= btn_rate;
            led     <= led_d;
            wrap    <= wrap_d;
            if (rate_press) rate_sel <= next_rate(rate_sel);
        end
    end

endmodule

// File: tb/tb_led_count_sequencer.sv
// Directed bench for led_count_sequencer with BASE_TICKS=16; AUTO_REVERSE_EN-aware.
module tb_led_count_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_go, btn_clr, btn_rate;
    logic [3:0] led;
    logic       running;
    logic [1:0] rate_sel;
    logic       tick;
    logic       wrap;

    int n_checks = 0;
    int n_errors = 0;
    int n_ticks;

`ifdef AUTO_REVERSE_EN
    localparam int LED_AT_WRAP   = 14;
    localparam int LED_AFTER_R3  = 12;
    localparam int LED_AFTER_R0  = 11;
    localparam int PERIODS_TO_9  = 2;
`else
    localparam int LED_AT_WRAP   = 0;
    localparam int LED_AFTER_R3  = 2;
    localparam int LED_AFTER_R0  = 3;
    localparam int PERIODS_TO_9  = 6;
`endif

    always #5 clk = ~clk;

    led_count_sequencer #(
        .CLK_HZ     (12_000_000),
        .BASE_TICKS (16),
        .PRESC_W    (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_go   (btn_go),
        .btn_clr  (btn_clr),
        .btn_rate (btn_rate),
        .led      (led),
        .running  (running),
        .rate_sel (rate_sel),
        .tick     (tick),
        .wrap     (wrap)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last edge.
    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press_go();
        btn_go = 1'b1; cycles(1); btn_go = 1'b0;
    endtask

    task automatic press_clr();
        btn_clr = 1'b1; cycles(1); btn_clr = 1'b0;
    endtask

    task automatic press_rate();
        btn_rate = 1'b1; cycles(1); btn_rate = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        btn_go   = 1'b1;
        btn_clr  = 1'b0;
        btn_rate = 1'b0;

        // Reset state, with go held through reset.
        #23;
        check("rst_led", led, 0);
        check("rst_running", running, 0);
        check("rst_rate", rate_sel, 0);
        check("rst_tick", tick, 0);
        check("rst_wrap", wrap, 0);
        rst_n = 1'b1;
        cycles(3);
        check("held_go_running", running, 0);
        check("held_go_led", led, 0);
        btn_go = 1'b0;
        cycles(2);
        check("go_low_running", running, 0);

        // Start at rate 0: first tick 16 cycles after the press edge.
        press_go();
        check("start_running", running, 1);
        check("start_led", led, 0);
        cycles(15);
        check("pre_tick1", tick, 0);
        cycles(1);
        check("tick1", tick, 1);
        check("led1", led, 1);
        cycles(1);
        check("tick1_pulse_end", tick, 0);
        cycles(63);
        check("led5", led, 5);
        check("tick_led5", tick, 1);

        // Pause 7 cycles into the period, hold 100 cycles, resume.
        cycles(6);
        press_go();
        check("hold_running", running, 0);
        n_ticks = 0;
        for (int i = 0; i < 100; i++) begin
            cycles(1);
            n_ticks += int'(tick);
        end
        check("hold_no_ticks", n_ticks, 0);
        check("hold_led", led, 5);
        press_go();
        check("resume_running", running, 1);
        cycles(8);
        check("resume_pre_tick", tick, 0);
        check("resume_pre_led", led, 5);
        cycles(1);
        check("resume_tick", tick, 1);
        check("resume_led6", led, 6);

        // Count to 15 and across the wrap/reversal.
        cycles(144);
        check("led15", led, 15);
        check("led15_wrap", wrap, 0);
        cycles(15);
        check("pre_wrap_tick", tick, 0);
        cycles(1);
        check("wrap_led", led, LED_AT_WRAP);
        check("wrap_pulse", wrap, 1);
        check("wrap_tick", tick, 1);
        cycles(1);
        check("wrap_pulse_end", wrap, 0);

        // Rate cycling: three presses to rate 3 (period 2), one more back to 0.
        press_rate();
        check("rate1", rate_sel, 1);
        cycles(1);
        press_rate();
        check("rate2", rate_sel, 2);
        cycles(1);
        press_rate();
        check("rate3", rate_sel, 3);
        cycles(1);
        check("r3_tick_a0", tick, 0);
        cycles(1);
        check("r3_tick_a1", tick, 1);
        cycles(1);
        check("r3_tick_b0", tick, 0);
        cycles(1);
        check("r3_tick_b1", tick, 1);
        check("r3_led", led, LED_AFTER_R3);
        press_rate();
        check("rate_wrap0", rate_sel, 0);
        cycles(15);
        check("r0_pre_tick", tick, 0);
        cycles(1);
        check("r0_tick", tick, 1);
        check("r0_led", led, LED_AFTER_R0);

        // clr and go together at led 9: clr wins, rate_sel kept.
        cycles(16 * PERIODS_TO_9);
        check("led9", led, 9);
        press_rate();
        cycles(1);
        btn_clr = 1'b1;
        btn_go  = 1'b1;
        cycles(1);
        btn_clr = 1'b0;
        btn_go  = 1'b0;
        check("clrgo_running", running, 0);
        check("clrgo_led", led, 0);
        check("clrgo_rate", rate_sel, 1);
        n_ticks = 0;
        for (int i = 0; i < 50; i++) begin
            cycles(1);
            n_ticks += int'(tick);
        end
        check("idle_no_ticks", n_ticks, 0);
        check("idle_running", running, 0);

        // Async reset mid-period.
        press_go();
        cycles(7);
        check("r1_pre_tick", tick, 0);
        cycles(1);
        check("r1_tick", tick, 1);
        check("r1_led", led, 1);
        cycles(3);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_led", led, 0);
        check("async_rst_running", running, 0);
        check("async_rst_rate", rate_sel, 0);
        rst_n = 1'b1;
        cycles(2);

`ifdef AUTO_REVERSE_EN
        // Bounce counting at rate 3.
        press_rate(); cycles(1);
        press_rate(); cycles(1);
        press_rate();
        check("rev_rate3", rate_sel, 3);
        press_go();
        cycles(30);
        check("rev_led15", led, 15);
        cycles(2);
        check("rev_led14", led, 14);
        check("rev_wrap_top", wrap, 1);
        cycles(1);
        check("rev_wrap_top_end", wrap, 0);
        cycles(27);
        check("rev_led0", led, 0);
        check("rev_led0_wrap", wrap, 0);
        cycles(2);
        check("rev_led1", led, 1);
        check("rev_wrap_bot", wrap, 1);
        cycles(34);
        check("rev_down12", led, 12);
        press_clr();
        check("rev_clr_led", led, 0);
        check("rev_clr_running", running, 0);
        press_go();
        cycles(2);
        check("rev_up1", led, 1);
        cycles(2);
        check("rev_up2", led, 2);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
